ws2812_serializer: RTL and testbench

- Downstream consumer of the pixel FIFO. Pops 24-bit GRB words over a valid/ready handshake and drives the one-wire WS2812 LED data line with cycle-counted high/low pulses.
- Inserts the latch/reset low period when the FIFO runs dry after a frame, then pulses frame_done.
- Sits between the pixel FIFO read port and the LED output pad.

---
 rtl/ws2812_pkg.sv | 20 ++
 rtl/ws2812_serializer.sv | 131 +++++++++++++
 tb/tb_ws2812_serializer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 one-wire LED serializer.
// FSM state encoding, default 50 MHz pulse timings and the pixel width.
package ws2812_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      LATCH = 2'd3
   } state_t;

   localparam int unsigned PIXEL_BITS    = 24;
   localparam int unsigned T0H_DEF       = 20;
   localparam int unsigned T0L_DEF       = 43;
   localparam int unsigned T1H_DEF       = 40;
   localparam int unsigned T1L_DEF       = 23;
   localparam int unsigned TRESET_DEF    = 2750;
   localparam int unsigned CNT_WIDTH_DEF = 12;

endpackage

// File: rtl/ws2812_serializer.sv
// Pops GRB words from the pixel FIFO and drives the WS2812 data line with
// cycle-counted high/low pulses, inserting the latch period when the FIFO runs dry.
module ws2812_serializer
   import ws2812_pkg::*;
#(
   parameter int unsigned DSIZE     = PIXEL_BITS,
   parameter int unsigned T0H       = T0H_DEF,
   parameter int unsigned T0L       = T0L_DEF,
   parameter int unsigned T1H       = T1H_DEF,
   parameter int unsigned T1L       = T1L_DEF,
   parameter int unsigned TRESET    = TRESET_DEF,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic [DSIZE-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             led_out,
   output logic             busy,
   output logic             frame_done
);

   localparam int unsigned   IW       = (DSIZE > 1) ? $clog2(DSIZE) : 1;
   localparam logic [IW-1:0] LAST_BIT = IW'(DSIZE - 1);

   state_t               state, state_nxt;
   logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
   logic [DSIZE-1:0]     shift, shift_nxt;
   logic [IW-1:0]        bit_idx, bit_idx_nxt;
   logic                 frame_done_nxt;
   logic                 accept;

   function automatic logic [CNT_WIDTH-1:0] high_reload(input logic b);
      return b ? CNT_WIDTH'(T1H - 1) : CNT_WIDTH'(T0H - 1);
   endfunction

   function automatic logic [CNT_WIDTH-1:0] low_reload(input logic b);
      return b ? CNT_WIDTH'(T1L - 1) : CNT_WIDTH'(T0L - 1);
   endfunction

   assign accept = in_valid && in_ready;

   // led_out is registered from the next state so it tracks HIGH cycle-exactly.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         shift      <= '0;
         bit_idx    <= '0;
         led_out    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         shift      <= shift_nxt;
         bit_idx    <= bit_idx_nxt;
         led_out    <= (state_nxt == HIGH);
         frame_done <= frame_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      shift_nxt      = shift;
      bit_idx_nxt    = bit_idx;
      frame_done_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               shift_nxt   = in_data;
               bit_idx_nxt = '0;
               state_nxt   = HIGH;
               cnt_nxt     = high_reload(in_data[DSIZE-1]);
            end
         end
         HIGH: begin
            if (cnt == '0) begin
               state_nxt = LOW;
               cnt_nxt   = low_reload(shift[DSIZE-1]);
            end else begin
               cnt_nxt = cnt - CNT_WIDTH'(1);
            end
         end
         LOW: begin
            if (cnt == '0) begin
               if (bit_idx != LAST_BIT) begin
                  shift_nxt   = {shift[DSIZE-2:0], 1'b0};
                  bit_idx_nxt = bit_idx + IW'(1);
                  state_nxt   = HIGH;
                  cnt_nxt     = high_reload(shift[DSIZE-2]);
               end else if (accept) begin
                  shift_nxt   = in_data;
                  bit_idx_nxt = '0;
                  state_nxt   = HIGH;
                  cnt_nxt     = high_reload(in_data[DSIZE-1]);
               end else begin
                  state_nxt = LATCH;
                  cnt_nxt   = CNT_WIDTH'(TRESET - 1);
               end
            end else begin
               cnt_nxt = cnt - CNT_WIDTH'(1);
            end
         end
         LATCH: begin
            if (cnt == '0) begin
               state_nxt      = IDLE;
               frame_done_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt - CNT_WIDTH'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Back-to-back pop only on the final LOW cycle of the last bit, so no gap appears.
   always_comb begin
      in_ready = 1'b0;
      if (!rst && enable) begin
         if (state == IDLE)
            in_ready = 1'b1;
         else if (state == LOW && cnt == '0 && bit_idx == LAST_BIT)
            in_ready = 1'b1;
      end
      busy = (state != IDLE);
   end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed and random bench for ws2812_serializer: a FIFO model feeds words, a
// waveform decoder rebuilds them from led_out and checks them against a scoreboard.
module tb_ws2812_serializer;

   localparam int unsigned DS  = 24;
   localparam int unsigned T0H = 2;
   localparam int unsigned T0L = 4;
   localparam int unsigned T1H = 4;
   localparam int unsigned T1L = 2;
   localparam int unsigned TR  = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [DS-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic          led_out;
   logic          busy;
   logic          frame_done;

   always #5 clk = ~clk;

   ws2812_serializer #(
      .DSIZE(DS), .T0H(T0H), .T0L(T0L), .T1H(T1H), .T1L(T1L),
      .TRESET(TR), .CNT_WIDTH(12)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .led_out(led_out),
      .busy(busy), .frame_done(frame_done)
   );

   int checks = 0;
   int failures = 0;

   logic [DS-1:0] src_q[$];
   logic [DS-1:0] exp_q[$];
   bit src_mode = 0;
   bit rand_gaps = 0;
   int gap_cnt = 0;
   int cyc = 0;
   int pops = 0;
   int last_pop_cyc = 0;
   int prev_pop_cyc = 0;
   int words_dec = 0;

   logic          prev_led = 1'b0;
   int            hlen = 0;
   int            llen = 0;
   int            nbits = 0;
   logic [DS-1:0] cur = '0;
   bit            have_prev = 0;
   bit            prev_last = 0;
   logic          prev_bit = 1'b0;
   bit            fd_in_run = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic dec_reset();
      prev_led  = 1'b0;
      hlen      = 0;
      llen      = 0;
      nbits     = 0;
      cur       = '0;
      have_prev = 0;
      prev_last = 0;
      fd_in_run = 0;
   endtask

   // Rebuild bits from pulse lengths; a low run longer than TxL must carry a frame_done.
   task automatic decode();
      int lowlen;
      if (frame_done) fd_in_run = 1;
      if (led_out) begin
         if (!prev_led) begin
            if (have_prev) begin
               lowlen = prev_bit ? int'(T1L) : int'(T0L);
               if (prev_last && fd_in_run) begin
                  chk1("latch_len", llen >= lowlen + int'(TR), 1'b1);
               end else begin
                  chk("low_len", llen, lowlen);
                  chk1("no_latch", fd_in_run, 1'b0);
               end
            end
            fd_in_run = 0;
            hlen = 0;
         end
         hlen++;
      end else begin
         if (prev_led) begin
            chk1("high_len", (hlen == int'(T0H)) || (hlen == int'(T1H)), 1'b1);
            prev_bit  = (hlen == int'(T1H));
            cur       = {cur[DS-2:0], prev_bit};
            nbits++;
            have_prev = 1;
            prev_last = (nbits == int'(DS));
            if (nbits == int'(DS)) begin
               nbits = 0;
               words_dec++;
               chk1("sb_nonempty", exp_q.size() != 0, 1'b1);
               if (exp_q.size() != 0) chk("pixel", 32'(cur), 32'(exp_q.pop_front()));
            end
            llen = 0;
         end
         llen++;
      end
      prev_led = led_out;
   endtask

   task automatic drive_src();
      if (rand_gaps) begin
         if (gap_cnt > 0) gap_cnt--;
         else if ($urandom_range(0, 59) == 0) gap_cnt = $urandom_range(1, 40);
      end
      in_valid = (src_q.size() > 0) && (gap_cnt == 0);
      in_data  = (src_q.size() > 0) ? src_q[0] : '0;
   endtask

   task automatic tick();
      bit hs;
      bit r;
      #1;
      hs = in_valid && in_ready;
      r  = rst;
      @(posedge clk);
      #1;
      cyc++;
      if (hs) begin
         pops++;
         prev_pop_cyc = last_pop_cyc;
         last_pop_cyc = cyc;
         exp_q.push_back(in_data);
         if (src_mode && src_q.size() > 0) void'(src_q.pop_front());
      end
      if (r) dec_reset();
      else decode();
      if (src_mode) drive_src();
   endtask

   task automatic wait_pop(input int limit);
      int p0;
      int n;
      p0 = pops;
      n = 0;
      while (pops == p0 && n < limit) begin
         tick();
         n++;
      end
      chk1("pop_seen", pops != p0, 1'b1);
   endtask

   task automatic wait_fd(input int limit, output int n);
      n = 0;
      while (!frame_done && n < limit) begin
         tick();
         n++;
      end
      chk1("fd_seen", frame_done, 1'b1);
   endtask

   initial begin
      int n;
      int p;
      int a;
      rst      = 1'b1;
      enable   = 1'b1;
      in_valid = 1'b1;
      in_data  = '0;

      // Reset holds everything low even with in_valid asserted
      repeat (3) begin
         tick();
         chk1("rst_in_ready", in_ready, 1'b0);
         chk1("rst_led", led_out, 1'b0);
         chk1("rst_busy", busy, 1'b0);
         chk1("rst_fd", frame_done, 1'b0);
      end
      rst = 1'b0;
      #1;
      chk1("ready_after_rst", in_ready, 1'b1);
      in_valid = 1'b0;
      tick();
      chk1("idle_busy", busy, 1'b0);

      // Single pixel: 144 bit cycles + 10 latch cycles, frame_done one cycle later
      src_mode = 1;
      src_q.push_back(24'hA50000);
      drive_src();
      p = pops;
      wait_pop(5);
      chk1("led_after_accept", led_out, 1'b1);
      wait_fd(400, n);
      chk("single_len", n, 154);
      chk1("single_busy_fall", busy, 1'b0);
      repeat (3) begin
         tick();
         chk1("fd_one_cycle", frame_done, 1'b0);
      end
      chk("single_pops", pops - p, 1);
      chk("single_sb_empty", exp_q.size(), 0);

      // Back-to-back pixels with no gap or latch between them
      src_q.push_back(24'hFFFFFF);
      src_q.push_back(24'h000000);
      drive_src();
      wait_pop(5);
      a = last_pop_cyc;
      wait_pop(200);
      chk("b2b_pop_gap", last_pop_cyc - a, 144);
      chk1("b2b_led_rise", led_out, 1'b1);
      wait_fd(400, n);
      chk("b2b_len", n, 154);
      chk("b2b_sb_empty", exp_q.size(), 0);

      // enable dropped mid-pixel: frame finishes, remaining words stay queued
      src_q.push_back(24'h123456);
      src_q.push_back(24'hABCDEF);
      src_q.push_back(24'h0F0F0F);
      src_q.push_back(24'hF0F0F0);
      drive_src();
      p = pops;
      wait_pop(5);
      repeat (50) tick();
      enable = 1'b0;
      wait_fd(300, n);
      chk("en_fifo_kept", src_q.size(), 3);
      chk("en_pops", pops - p, 1);
      repeat (5) begin
         tick();
         chk1("en_ready_low", in_ready, 1'b0);
         chk1("en_idle", busy, 1'b0);
      end
      enable = 1'b1;
      wait_fd(800, n);
      chk("en_resume_empty", src_q.size(), 0);
      chk("en_sb_empty", exp_q.size(), 0);

      // Reset during HIGH of bit 5 drops the word in flight
      src_q.push_back(24'h5A5A5A);
      drive_src();
      wait_pop(5);
      repeat (30) tick();
      chk1("bit5_high", led_out, 1'b1);
      rst = 1'b1;
      tick();
      chk1("midrst_led", led_out, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_ready", in_ready, 1'b0);
      rst = 1'b0;
      exp_q.delete();
      p = pops;
      repeat (5) tick();
      chk("midrst_no_reread", pops - p, 0);
      src_q.push_back(24'h800000);
      drive_src();
      wait_pop(5);
      n = 0;
      while (led_out && n < 10) begin
         tick();
         n++;
      end
      chk("post_rst_first_high", n, 4);
      wait_fd(400, n);
      chk("post_rst_sb_empty", exp_q.size(), 0);

      // Random words with random in_valid gaps
      rand_gaps = 1;
      p = pops;
      a = words_dec;
      for (int i = 0; i < 100; i++) src_q.push_back(24'($urandom()));
      drive_src();
      n = 0;
      while ((src_q.size() > 0 || busy) && n < 40000) begin
         tick();
         n++;
      end
      chk1("rand_done", busy, 1'b0);
      chk("rand_src_empty", src_q.size(), 0);
      chk("rand_pops", pops - p, 100);
      chk("rand_decoded", words_dec - a, 100);
      chk("rand_sb_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
